// File: rtl/select_sequencer.sv
// Registered 2-bit select generator for a 2x4 decoder: scans 00..11 with a
// programmable dwell, supports manual load in IDLE and start/stop control.
module select_sequencer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [1:0] load_sel,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       step,
  output logic       wrap
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 step_q, step_d;
  logic                 wrap_q, wrap_d;

  // State register: every decoder-facing output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // stop blocks both load and start; load blocks a same-edge start
        if (stop) begin
          state_d = IDLE;
        end else if (load) begin
          sel_d = load_sel;
        end else if (start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          sel_d  = sel_q + 2'd1;
          cnt_d  = '0;
          step_d = 1'b1;
          wrap_d = (sel_q == 2'b11);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = (state_q == SCAN);
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_select_sequencer.sv
// Scoreboard bench for select_sequencer: DWELL=4 and DWELL=1 instances driven
// by directed vectors; a monitor pops expected {s1,s0,busy,step,wrap} per cycle.
`timescale 1ns/1ps
module tb_select_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DWELL=4
  logic       rst_na, start_a, stop_a, load_a;
  logic [1:0] lsel_a;
  logic       s1_a, s0_a, busy_a, step_a, wrap_a;
  // Instance B: DWELL=1
  logic       rst_nb, start_b, stop_b, load_b;
  logic [1:0] lsel_b;
  logic       s1_b, s0_b, busy_b, step_b, wrap_b;

  select_sequencer #(.DWELL(4), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_na), .start(start_a), .stop(stop_a), .load(load_a),
    .load_sel(lsel_a), .s1(s1_a), .s0(s0_a), .busy(busy_a), .step(step_a),
    .wrap(wrap_a)
  );

  select_sequencer #(.DWELL(1), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .stop(stop_b), .load(load_b),
    .load_sel(lsel_b), .s1(s1_b), .s0(s0_b), .busy(busy_b), .step(step_b),
    .wrap(wrap_b)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] qa[$];
  logic [4:0] qb[$];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (s1s0,busy,step,wrap)", name, act, exp);
    end
  endtask

  task automatic chk_onehot(input string name, input logic [1:0] sel);
    logic [3:0] dec;
    dec = 4'b0001 << sel;
    checks++;
    if (!$onehot(dec) || $isunknown(sel)) begin
      errors++;
      $display("FAIL %s: decoder outputs %b not one-hot", name, dec);
    end
  endtask

  // Monitor: samples 2ns after each rising edge, away from input changes.
  always @(posedge clk) begin
    logic [4:0] e;
    #2;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("scan_a", {s1_a, s0_a, busy_a, step_a, wrap_a}, e);
      chk_onehot("onehot_a", {s1_a, s0_a});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("scan_b", {s1_b, s0_b, busy_b, step_b, wrap_b}, e);
      chk_onehot("onehot_b", {s1_b, s0_b});
    end
  end

  task automatic cyc_a(input logic st, input logic sp, input logic ld, input logic [1:0] ls,
                       input logic [1:0] es, input logic eb, input logic estp, input logic ewr);
    @(negedge clk);
    start_a = st; stop_a = sp; load_a = ld; lsel_a = ls;
    qa.push_back({es, eb, estp, ewr});
  endtask

  task automatic cyc_b(input logic st, input logic sp, input logic ld, input logic [1:0] ls,
                       input logic [1:0] es, input logic eb, input logic estp, input logic ewr);
    @(negedge clk);
    start_b = st; stop_b = sp; load_b = ld; lsel_b = ls;
    qb.push_back({es, eb, estp, ewr});
  endtask

  initial begin
    rst_na = 1'b0; start_a = 1'b0; stop_a = 1'b0; load_a = 1'b0; lsel_a = 2'b00;
    rst_nb = 1'b0; start_b = 1'b0; stop_b = 1'b0; load_b = 1'b0; lsel_b = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {s1_a, s0_a, busy_a, step_a, wrap_a}, 5'b00000);
    chk("reset_b", {s1_b, s0_b, busy_b, step_b, wrap_b}, 5'b00000);
    @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1;

    // Full scan from 00: each value held 4 cycles, wrap only on 11->00
    cyc_a(1, 0, 0, 2'd0, 2'd0, 1, 0, 0);
    repeat (3) cyc_a(0, 0, 0, 2'd0, 2'd0, 1, 0, 0);
    for (int v = 1; v <= 4; v++) begin
      cyc_a(0, 0, 0, 2'd0, 2'(v % 4), 1, 1, (v == 4));
      if (v < 4) repeat (3) cyc_a(0, 0, 0, 2'd0, 2'(v), 1, 0, 0);
    end
    cyc_a(0, 1, 0, 2'd0, 2'd0, 0, 0, 0);

    // Load 10 in IDLE, then scan: first advance to 11 after 4 cycles
    cyc_a(0, 0, 1, 2'd2, 2'd2, 0, 0, 0);
    cyc_a(1, 0, 0, 2'd0, 2'd2, 1, 0, 0);
    repeat (3) cyc_a(0, 0, 0, 2'd0, 2'd2, 1, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd3, 1, 1, 0);
    repeat (3) cyc_a(0, 0, 0, 2'd0, 2'd3, 1, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd0, 1, 1, 1);
    repeat (3) cyc_a(0, 0, 0, 2'd0, 2'd0, 1, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd1, 1, 1, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd1, 1, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd1, 1, 0, 0);

    // Stop at sel=01 count=2: freeze 01; restart holds 01 a full 4 cycles (start held high)
    cyc_a(0, 1, 0, 2'd0, 2'd1, 0, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd1, 0, 0, 0);
    cyc_a(1, 0, 0, 2'd0, 2'd1, 1, 0, 0);
    repeat (3) cyc_a(1, 0, 0, 2'd0, 2'd1, 1, 0, 0);
    cyc_a(1, 0, 0, 2'd0, 2'd2, 1, 1, 0);

    // Conflicts: load ignored in SCAN, stop beats start, load beats start, stop beats load
    cyc_a(0, 0, 1, 2'd0, 2'd2, 1, 0, 0);
    cyc_a(1, 1, 0, 2'd0, 2'd2, 0, 0, 0);
    cyc_a(1, 0, 1, 2'd1, 2'd1, 0, 0, 0);
    cyc_a(0, 1, 1, 2'd3, 2'd1, 0, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd1, 0, 0, 0);

    // Asynchronous reset mid-cycle while step is high
    cyc_a(1, 0, 0, 2'd0, 2'd1, 1, 0, 0);
    repeat (3) cyc_a(0, 0, 0, 2'd0, 2'd1, 1, 0, 0);
    cyc_a(0, 0, 0, 2'd0, 2'd2, 1, 1, 0);
    @(posedge clk);
    #3 rst_na = 1'b0;
    #1 chk("midreset_a", {s1_a, s0_a, busy_a, step_a, wrap_a}, 5'b00000);
    rst_na = 1'b1;
    cyc_a(0, 0, 0, 2'd0, 2'd0, 0, 0, 0);

    // DWELL=1: advance every edge, step continuous, wrap every 4th
    cyc_b(1, 0, 0, 2'd0, 2'd0, 1, 0, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd1, 1, 1, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd2, 1, 1, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd3, 1, 1, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd0, 1, 1, 1);
    cyc_b(0, 0, 0, 2'd0, 2'd1, 1, 1, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd2, 1, 1, 0);
    @(posedge clk);
    #3 rst_nb = 1'b0;
    #1 chk("midreset_b", {s1_b, s0_b, busy_b, step_b, wrap_b}, 5'b00000);
    rst_nb = 1'b1;
    cyc_b(0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
    cyc_b(1, 0, 0, 2'd0, 2'd0, 1, 0, 0);
    cyc_b(0, 0, 0, 2'd0, 2'd1, 1, 1, 0);
    cyc_b(0, 1, 0, 2'd0, 2'd1, 0, 0, 0);

    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d required 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
